// File: rtl/mesm6_bus_pkg.sv
// mesm6_bus_pkg: shared widths and FSM state type for the MESM-6 memory bus arbiter
package mesm6_bus_pkg;
    localparam int ADDR_BITS = 15;
    localparam int WORD_BITS = 48;
    typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} bus_state_t;
endpackage

// File: rtl/mesm6_bus_watchdog.sv
// mesm6_bus_watchdog: loadable down-counter that flags a stalled memory transaction
// ports: clk, reset (sync, high), load (reload with TIMEOUT), dec (count down), expired (count is 0)
module mesm6_bus_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= W'(TIMEOUT);
        else if (dec && !expired) count <= count - W'(1);
    end
    assign expired = count == '0;
endmodule

// File: rtl/mesm6_bus_arbiter.sv
// mesm6_bus_arbiter: round-robin sharing of one memory port between instruction fetch and data buses
// ports: clk, reset (sync, high); ibus_* fetch request/address/data/done; dbus_* read/write request,
//        address, write data, read data, done; mem_* strobes, address, data, completion; bus_error on timeout
module mesm6_bus_arbiter
    import mesm6_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ibus_fetch,
    input  logic [ADDR_BITS-1:0] ibus_addr,
    output logic [WORD_BITS-1:0] ibus_input,
    output logic                 ibus_done,
    input  logic                 dbus_read,
    input  logic                 dbus_write,
    input  logic [ADDR_BITS-1:0] dbus_addr,
    input  logic [WORD_BITS-1:0] dbus_output,
    output logic [WORD_BITS-1:0] dbus_input,
    output logic                 dbus_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic [WORD_BITS-1:0] mem_rdata,
    input  logic                 mem_done,
    output logic                 bus_error
);
    bus_state_t           state;
    logic                 last_d;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_BITS-1:0] wdata_q;
    logic                 idle, busy, grant_d, grant_i, expired, finish;
    assign idle    = state == IDLE;
    assign busy    = !idle;
    // on a tie the side not served last wins
    assign grant_d = idle && (dbus_read || dbus_write) && (!ibus_fetch || !last_d);
    assign grant_i = idle && ibus_fetch && !grant_d;
    // a reset in the completing cycle suppresses the done pulse
    assign finish  = busy && !reset && (mem_done || expired);
    mesm6_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .load    (grant_d || grant_i),
        .dec     (busy && !mem_done),
        .expired (expired)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_d || grant_i) begin
            state  <= grant_i ? FETCH : (dbus_write ? DWRITE : DREAD);
            last_d <= grant_d;
            addr_q <= grant_d ? dbus_addr : ibus_addr;
            if (grant_d && dbus_write) wdata_q <= dbus_output;
        end else if (finish) begin
            state <= IDLE;
        end
    end
    assign mem_read   = state == FETCH || state == DREAD;
    assign mem_write  = state == DWRITE;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign ibus_done  = finish && state == FETCH;
    assign dbus_done  = finish && state != FETCH;
    // a timed-out transaction returns zero data; a real completion wins over expiry
    assign ibus_input = ibus_done && mem_done ? mem_rdata : '0;
    assign dbus_input = dbus_done && mem_done ? mem_rdata : '0;
    assign bus_error  = finish && !mem_done;
endmodule
